// File: rtl/fp16_add_sched.sv
// Round-robin scheduler sharing one pipelined FP16 adder among NREQ
// requesters, with per-requester credits and a fixed-latency tag pipe.
module fp16_add_sched #(
  parameter int NREQ    = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  input  logic [NREQ*2-1:0] req_rm,
  output logic              add_valid,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_sub,
  output logic [1:0]        add_rm,
  input  logic [15:0]       add_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_data,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gid;
  logic [IW-1:0]   add_id;
  logic            gnt;
  logic [NREQ-1:0] elig;
  logic [2:0]      cnt [NREQ];
  logic [LAT-1:0]  tv;
  logic [IW-1:0]   tid [LAT];
  logic [IW:0]     sum;
  logic [IW-1:0]   idx;

  // A requester may compete only while it has a free credit
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt[i] < 3'(MAX_OUT));
    end
  end

  // Round-robin search starting at ptr, wrapping at NREQ
  always_comb begin
    gnt       = 1'b0;
    gid       = '0;
    sum       = '0;
    idx       = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!gnt && elig[idx]) begin
        gnt = 1'b1;
        gid = idx;
      end
    end
    if (rst) gnt = 1'b0;
    if (gnt) req_ready[gid] = 1'b1;
  end

  // Issue register: capture the granted operands, advance the RR pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_sub   <= 1'b0;
      add_rm    <= '0;
      add_id    <= '0;
    end else begin
      add_valid <= gnt;
      if (gnt) begin
        ptr     <= (gid == IW'(NREQ-1)) ? '0 : gid + 1'b1;
        add_a   <= req_a[16*gid +: 16];
        add_b   <= req_b[16*gid +: 16];
        add_sub <= req_sub[gid];
        add_rm  <= req_rm[2*gid +: 2];
        add_id  <= gid;
      end
    end
  end

  // Tag pipe tracks which requester owns each op inside the adder
  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
      for (int s = 0; s < LAT; s++) tid[s] <= '0;
    end else begin
      tv[0]  <= add_valid;
      tid[0] <= add_id;
      for (int s = 1; s < LAT; s++) begin
        tv[s]  <= tv[s-1];
        tid[s] <= tid[s-1];
      end
    end
  end

  // Register the adder result and strobe the owning requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tv[LAT-1]) begin
        rsp_valid[tid[LAT-1]] <= 1'b1;
        rsp_data              <= add_result;
      end
    end
  end

  // Credits: take one on accept, return one on response
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        unique case ({gnt && (gid == IW'(i)), rsp_valid[i]})
          2'b10:   cnt[i] <= cnt[i] + 3'd1;
          2'b01:   cnt[i] <= cnt[i] - 3'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign busy = add_valid | (|tv) | (|rsp_valid);

endmodule
